// File: rtl/main_full_adder_if.sv
// Operand/result bundle for main_full_adder; the master drives operands and enable,
// the slave returns the combinational and registered results.
interface main_full_adder_if #(
  parameter int WIDTH = 1
) ();
  logic             en;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             z;
  logic [WIDTH-1:0] s;
  logic             c;
  logic [WIDTH-1:0] s_q;
  logic             c_q;
  logic             valid_q;

  modport master (
    output en, x, y, z,
    input  s, c, s_q, c_q, valid_q
  );

  modport slave (
    input  en, x, y, z,
    output s, c, s_q, c_q, valid_q
  );
endinterface

// File: rtl/main_full_adder.sv
// WIDTH-bit full adder: zero-latency {c,s} = x + y + z plus a one-cycle registered copy.
// No backpressure; en=0 holds the registered sum and drops valid_q.
module main_full_adder #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  main_full_adder_if.slave   bus
);

  logic [WIDTH:0]   total;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             carry_d, carry_q;
  logic             vld_d, vld_q;

  // Extended by one bit so the carry-out is never truncated.
  assign total = {1'b0, bus.x} + {1'b0, bus.y} + {{WIDTH{1'b0}}, bus.z};

  assign bus.s = total[WIDTH-1:0];
  assign bus.c = total[WIDTH];

  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    vld_d   = 1'b0;
    if (bus.en) begin
      sum_d   = total[WIDTH-1:0];
      carry_d = total[WIDTH];
      vld_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.s_q     = sum_q;
  assign bus.c_q     = carry_q;
  assign bus.valid_q = vld_q;

endmodule

// File: tb/tb_main_full_adder.sv
// Directed test-plan steps followed by randomized traffic, for WIDTH=1 and WIDTH=8 instances.
module tb_main_full_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  main_full_adder_if #(.WIDTH(1)) b1 ();
  main_full_adder_if #(.WIDTH(8)) b8 ();

  main_full_adder #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  main_full_adder #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

  int checks = 0;
  int errors = 0;

  // Reference model of the registered outputs, advanced once per clock edge
  logic       m1_s, m1_c, m1_v;
  logic [7:0] m8_s;
  logic       m8_c, m8_v;
  logic [1:0] tt [8];

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [1:0] sum1;
    logic [8:0] sum8;
    sum1 = 2'(b1.x) + 2'(b1.y) + 2'(b1.z);
    sum8 = 9'(b8.x) + 9'(b8.y) + 9'(b8.z);
    if (!rst_n) begin
      m1_s = 1'b0; m1_c = 1'b0; m1_v = 1'b0;
      m8_s = 8'h00; m8_c = 1'b0; m8_v = 1'b0;
    end else begin
      if (b1.en) begin
        m1_s = sum1[0]; m1_c = sum1[1]; m1_v = 1'b1;
      end else begin
        m1_v = 1'b0;
      end
      if (b8.en) begin
        m8_s = sum8[7:0]; m8_c = sum8[8]; m8_v = 1'b1;
      end else begin
        m8_v = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_comb_model();
    chk("comb_w1", {b1.c, b1.s}, 2'(b1.x) + 2'(b1.y) + 2'(b1.z));
    chk("comb_w8", {b8.c, b8.s}, 9'(b8.x) + 9'(b8.y) + 9'(b8.z));
  endtask

  task automatic chk_reg_model();
    chk("reg_w1", {b1.valid_q, b1.c_q, b1.s_q}, {m1_v, m1_c, m1_s});
    chk("reg_w8", {b8.valid_q, b8.c_q, b8.s_q}, {m8_v, m8_c, m8_s});
  endtask

  initial begin
    tt = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
    rst_n = 1'b0;
    b1.en = 1'b0; b1.x = '0; b1.y = '0; b1.z = 1'b0;
    b8.en = 1'b0; b8.x = '0; b8.y = '0; b8.z = 1'b0;

    // WIDTH=1 truth table, checked between clock edges
    for (int i = 0; i < 8; i++) begin
      {b1.x, b1.y, b1.z} = 3'(i);
      #10;
      chk("truth_table", {b1.c, b1.s}, tt[i]);
    end

    @(posedge clk);
    #1;

    // Reset held for two edges with en=1 and all-ones operands
    rst_n = 1'b0;
    b1.en = 1'b1; b1.x = 1'b1; b1.y = 1'b1; b1.z = 1'b1;
    b8.en = 1'b1; b8.x = 8'hFF; b8.y = 8'hFF; b8.z = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("rst_reg_w1", {b1.valid_q, b1.c_q, b1.s_q}, 3'b000);
      chk("rst_reg_w8", {b8.valid_q, b8.c_q, b8.s_q}, 10'h000);
      chk("rst_comb_w1", {b1.c, b1.s}, 2'b11);
      chk("overflow_w8", {b8.c, b8.s}, 9'h1FF);
    end

    // Release and capture one result
    rst_n = 1'b1;
    b1.x = 1'b1; b1.y = 1'b0; b1.z = 1'b1;
    b8.x = 8'hFF; b8.y = 8'h01; b8.z = 1'b1;
    #1;
    chk("comb_ff_01_1", {b8.c, b8.s}, 9'h101);
    step();
    chk("capture_w1", {b1.valid_q, b1.c_q, b1.s_q}, 3'b110);
    chk("capture_w8", {b8.valid_q, b8.c_q, b8.s_q}, 10'h301);
    chk_reg_model();

    // Enable low: registered results hold, valid drops, combinational follows inputs
    b1.en = 1'b0; b1.x = 1'b0; b1.y = 1'b0; b1.z = 1'b0;
    b8.en = 1'b0; b8.x = 8'h00; b8.y = 8'h00; b8.z = 1'b0;
    #1;
    chk("zero_comb_w1", {b1.c, b1.s}, 2'b00);
    chk("zero_comb_w8", {b8.c, b8.s}, 9'h000);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_w1", {b1.valid_q, b1.c_q, b1.s_q}, 3'b010);
      chk("hold_w8", {b8.valid_q, b8.c_q, b8.s_q}, 10'h101);
    end

    b8.x = 8'h7F; b8.y = 8'h00; b8.z = 1'b0;
    #1;
    chk("comb_7f", {b8.c, b8.s}, 9'h07F);
    b8.en = 1'b1;
    step();
    chk("capture_7f", {b8.valid_q, b8.c_q, b8.s_q}, 10'h27F);

    // Reset and enable on the same edge: reset wins
    rst_n = 1'b0;
    b1.en = 1'b1; b1.x = 1'b1; b1.y = 1'b1; b1.z = 1'b0;
    b8.en = 1'b1; b8.x = 8'hA5; b8.y = 8'h5A; b8.z = 1'b1;
    step();
    chk("rst_wins_w1", {b1.valid_q, b1.c_q, b1.s_q}, 3'b000);
    chk("rst_wins_w8", {b8.valid_q, b8.c_q, b8.s_q}, 10'h000);

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      rst_n = ($urandom_range(0, 15) != 0);
      b1.en = 1'($urandom_range(0, 1));
      b8.en = 1'($urandom_range(0, 1));
      b1.x = 1'($urandom); b1.y = 1'($urandom); b1.z = 1'($urandom);
      b8.x = 8'($urandom); b8.y = 8'($urandom); b8.z = 1'($urandom);
      #1;
      chk_comb_model();
      step();
      chk_reg_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
